// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time imem requests and
// buffers returned words in a 2-entry queue feeding the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] addr_o,
    output logic [31:0] instr_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        head_v_q, head_v_d, tail_v_q, tail_v_d;
    logic [31:0] head_instr_q, head_instr_d, head_addr_q, head_addr_d;
    logic [31:0] tail_instr_q, tail_instr_d, tail_addr_q, tail_addr_d;
    logic        flush_q, flush_d;

    logic        ack;
    logic        pop;
    logic        push;
    logic        still_outstanding;
    logic        do_issue;

    assign ack               = (state_q != IDLE) && imem_ack_i;
    assign pop               = head_v_q && !stall_i;
    assign push              = ack && (state_q == BUSY);
    assign still_outstanding = (state_q != IDLE) && !imem_ack_i;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        head_v_d     = head_v_q;
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        tail_v_d     = tail_v_q;
        tail_instr_d = tail_instr_q;
        tail_addr_d  = tail_addr_q;
        flush_d      = 1'b0;
        do_issue     = 1'b0;

        if (redirect_i) begin
            head_v_d     = 1'b0;
            head_instr_d = '0;
            head_addr_d  = '0;
            tail_v_d     = 1'b0;
            tail_instr_d = '0;
            tail_addr_d  = '0;
            fetch_pc_d   = redirect_addr_i;
            flush_d      = 1'b1;
            state_d      = still_outstanding ? DROP : IDLE;
        end else begin
            // Invalid slots are kept at zero so a pop from a single entry
            // leaves a clean bubble on addr_o/instr_o.
            if (pop) begin
                head_v_d     = tail_v_q;
                head_instr_d = tail_instr_q;
                head_addr_d  = tail_addr_q;
                tail_v_d     = 1'b0;
                tail_instr_d = '0;
                tail_addr_d  = '0;
            end
            if (push) begin
                if (!head_v_d) begin
                    head_v_d     = 1'b1;
                    head_instr_d = imem_data_i;
                    head_addr_d  = req_pc_q + 32'd4;
                end else begin
                    tail_v_d     = 1'b1;
                    tail_instr_d = imem_data_i;
                    tail_addr_d  = req_pc_q + 32'd4;
                end
            end

            if (ack) begin
                state_d = IDLE;
            end
            // A completed DROP handshake returns to IDLE; issue resumes next edge.
            do_issue = !still_outstanding && !tail_v_d && (state_q != DROP);
            if (do_issue) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                state_d    = BUSY;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            head_v_q     <= 1'b0;
            head_instr_q <= '0;
            head_addr_q  <= '0;
            tail_v_q     <= 1'b0;
            tail_instr_q <= '0;
            tail_addr_q  <= '0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            head_v_q     <= head_v_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            tail_v_q     <= tail_v_d;
            tail_instr_q <= tail_instr_d;
            tail_addr_q  <= tail_addr_d;
            flush_q      <= flush_d;
        end
    end

    assign imem_req_o  = (state_q != IDLE);
    assign imem_addr_o = req_pc_q;
    assign valid_o     = head_v_q;
    assign addr_o      = head_addr_q;
    assign instr_o     = head_instr_q;
    assign flush_o     = flush_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory responder with variable latency and a
// stream-level model of the expected fetch and consume order.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] raddr = '0;
    logic        ack = 1'b0;
    logic [31:0] data = '0;
    logic        req, valid, flush;
    logic [31:0] iaddr, addr, instr;

    logic        rst_nw = 1'b0;
    logic        w_req, w_valid, w_flush, w_ack;
    logic [31:0] w_iaddr, w_addr, w_instr, w_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .redirect_i(redir),
        .redirect_addr_i(raddr), .imem_req_o(req), .imem_addr_o(iaddr),
        .imem_ack_i(ack), .imem_data_i(data), .valid_o(valid), .addr_o(addr),
        .instr_o(instr), .flush_o(flush)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i(clk), .rst_n_i(rst_nw), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_addr_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_iaddr),
        .imem_ack_i(w_ack), .imem_data_i(w_data), .valid_o(w_valid), .addr_o(w_addr),
        .instr_o(w_instr), .flush_o(w_flush)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    assign w_ack  = w_req;
    assign w_data = memf(w_iaddr);

    logic [31:0] exp_fetch, exp_cons, prev_addr, prev_instr, prev_addro, force_raddr;
    logic        exp_flush, prev_req, prev_ack, prev_hold, force_stall, force_redir;
    int          mem_cnt, cur_lat, lat_lo, lat_hi, stall_pct, redir_pct, n_cons, n_acks;

    task automatic reset_model();
        exp_fetch = 32'h0;  exp_cons = 32'h0;  exp_flush = 1'b0;
        prev_req = 1'b0;    prev_ack = 1'b0;   prev_hold = 1'b0;
        prev_addr = '0;     prev_instr = '0;   prev_addro = '0;
        mem_cnt = 0;        cur_lat = lat_lo;
    endtask

    // One cycle: sample at negedge, check, then drive the inputs for the next posedge.
    task automatic step();
        logic new_req;
        @(negedge clk);
        checks++;
        if (valid === 1'b0) begin
            if ({addr, instr} !== 64'h0) begin
                failures++;
                $display("FAIL bubble: addr_o=%h instr_o=%h, required 0/0", addr, instr);
            end
        end else if (instr !== memf(addr - 32'd4)) begin
            failures++;
            $display("FAIL data: addr_o=%h instr_o=%h, required %h", addr, instr, memf(addr - 32'd4));
        end
        checks++;
        if (flush !== exp_flush) begin
            failures++;
            $display("FAIL flush: flush_o=%b, required %b", flush, exp_flush);
        end
        if (prev_req && !prev_ack) begin
            checks++;
            if (req !== 1'b1 || iaddr !== prev_addr) begin
                failures++;
                $display("FAIL req_hold: req=%b addr=%h, required 1/%h", req, iaddr, prev_addr);
            end
        end
        new_req = (req === 1'b1) && (!prev_req || prev_ack);
        if (new_req) begin
            checks++;
            if (iaddr !== exp_fetch) begin
                failures++;
                $display("FAIL fetch_order: imem_addr_o=%h, required %h", iaddr, exp_fetch);
            end
            exp_fetch = exp_fetch + 32'd4;
        end
        if (prev_hold) begin
            checks++;
            if (valid !== 1'b1 || addr !== prev_addro || instr !== prev_instr) begin
                failures++;
                $display("FAIL stall_hold: v=%b addr=%h instr=%h, required 1/%h/%h",
                         valid, addr, instr, prev_addro, prev_instr);
            end
        end

        stall = force_stall || (int'($urandom_range(0, 99)) < stall_pct);
        redir = force_redir || (int'($urandom_range(0, 99)) < redir_pct);
        raddr = force_redir ? force_raddr : ($urandom & 32'h0000_0FFF);
        if (req === 1'b1 && mem_cnt >= cur_lat) begin
            ack = 1'b1;  data = memf(iaddr);
        end else begin
            ack = 1'b0;  data = $urandom;
        end

        if (redir) begin
            exp_fetch = raddr;  exp_cons = raddr;  exp_flush = 1'b1;
        end else begin
            exp_flush = 1'b0;
            if (valid === 1'b1 && !stall) begin
                checks++;
                if (addr !== exp_cons + 32'd4 || instr !== memf(exp_cons)) begin
                    failures++;
                    $display("FAIL seq: addr_o=%h instr_o=%h, required %h/%h",
                             addr, instr, exp_cons + 32'd4, memf(exp_cons));
                end
                exp_cons = exp_cons + 32'd4;
                n_cons++;
            end
        end
        prev_hold  = (valid === 1'b1) && stall && !redir;
        prev_instr = instr;  prev_addro = addr;
        prev_req   = (req === 1'b1);  prev_ack = ack;  prev_addr = iaddr;
        if (req === 1'b1 && ack) begin
            mem_cnt = 0;  cur_lat = int'($urandom_range(lat_hi, lat_lo));  n_acks++;
        end else if (req === 1'b1) begin
            mem_cnt++;
        end else begin
            mem_cnt = 0;
        end
    endtask

    task automatic set_mode(input int lo, input int hi, input int sp, input int rp);
        lat_lo = lo;  lat_hi = hi;  stall_pct = sp;  redir_pct = rp;
    endtask

    task automatic do_reset(input logic late_ack);
        @(negedge clk);
        #1;
        rst_n = 1'b0;  stall = 1'b0;  redir = 1'b0;  ack = 1'b0;
        #1;
        checks++;
        if ({req, iaddr, valid, addr, instr, flush} !== 99'h0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b ia=%h v=%b a=%h i=%h f=%b, required all 0",
                     req, iaddr, valid, addr, instr, flush);
        end
        @(negedge clk);
        rst_n = 1'b1;
        if (late_ack) begin
            ack = 1'b1;  data = 32'hDEAD_BEEF;
        end
        reset_model();
    endtask

    task automatic test_reset();
        set_mode(0, 0, 0, 0);
        #3;
        checks++;
        if ({req, iaddr, valid, addr, instr, flush} !== 99'h0) begin
            failures++;
            $display("FAIL por_outputs: req=%b ia=%h v=%b, required all 0", req, iaddr, valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        step();
        checks++;
        if (req !== 1'b1 || iaddr !== 32'h0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL first_req: req=%b addr=%h v=%b, required 1/0/0", req, iaddr, valid);
        end
    endtask

    task automatic test_zero_wait();
        set_mode(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (valid !== 1'b1 || req !== 1'b1) begin
                failures++;
                $display("FAIL zero_wait_rate: valid=%b req=%b, required 1/1", valid, req);
            end
        end
    endtask

    task automatic test_wait2();
        int nv;
        set_mode(2, 2, 0, 0);
        for (int i = 0; i < 12; i++) step();
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 10) begin
            failures++;
            $display("FAIL wait2_rate: valid cycles=%0d of 30, required 10", nv);
        end
    endtask

    task automatic test_stall();
        int a0;
        set_mode(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();
        a0 = n_acks;
        force_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 2) begin
                checks++;
                if (req !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_req: imem_req_o=%b after %0d stall edges, required 0", req, i);
                end
            end
        end
        force_stall = 1'b0;
        checks++;
        if (n_acks - a0 > 2) begin
            failures++;
            $display("FAIL stall_accept: accepted %0d words, required <= 2", n_acks - a0);
        end
        step();
        step();
        checks++;
        if (req !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume: imem_req_o=%b, required 1", req);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_redirect_drop();
        int k;
        set_mode(3, 3, 0, 0);
        do_reset(1'b0);
        k = 0;
        do begin
            step();
            k++;
        end while (!(req === 1'b1 && iaddr === 32'h20) && k < 100);
        checks++;
        if (k >= 100) begin
            failures++;
            $display("FAIL drop_setup: no request for 0x20 seen, imem_addr_o=%h", iaddr);
        end
        force_redir = 1'b1;  force_raddr = 32'h100;
        step();
        force_redir = 1'b0;
        step();
        checks++;
        if (flush !== 1'b1 || valid !== 1'b0 || req !== 1'b1 || iaddr !== 32'h20) begin
            failures++;
            $display("FAIL drop_state: f=%b v=%b req=%b ia=%h, required 1/0/1/00000020",
                     flush, valid, req, iaddr);
        end
        k = 0;
        do begin
            step();
            k++;
        end while (valid !== 1'b1 && k < 40);
        checks++;
        if (addr !== 32'h104 || instr !== memf(32'h100)) begin
            failures++;
            $display("FAIL drop_target: addr_o=%h instr_o=%h, required 00000104/%h",
                     addr, instr, memf(32'h100));
        end
    endtask

    task automatic test_redirect_ack();
        int k;
        set_mode(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        k = 0;
        while (req !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        force_redir = 1'b1;  force_raddr = 32'h200;
        step();
        force_redir = 1'b0;
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL redir_ack_setup: ack=%b, required 1", ack);
        end
        step();
        checks++;
        if (req !== 1'b0 || flush !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_ack_idle: req=%b f=%b v=%b, required 0/1/0", req, flush, valid);
        end
        step();
        checks++;
        if (req !== 1'b1 || iaddr !== 32'h200 || flush !== 1'b0) begin
            failures++;
            $display("FAIL redir_ack_issue: req=%b ia=%h f=%b, required 1/00000200/0", req, iaddr, flush);
        end
        step();
        checks++;
        if (valid !== 1'b1 || addr !== 32'h204) begin
            failures++;
            $display("FAIL redir_ack_target: v=%b addr_o=%h, required 1/00000204", valid, addr);
        end
    endtask

    task automatic test_random();
        int c0;
        set_mode(0, 3, 30, 4);
        c0 = n_cons;
        for (int i = 0; i < 1500; i++) step();
        checks++;
        if (n_cons - c0 < 100) begin
            failures++;
            $display("FAIL progress: consumed %0d instructions, required >= 100", n_cons - c0);
        end
        set_mode(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_reset_mid();
        int k;
        set_mode(3, 3, 0, 0);
        k = 0;
        do begin
            step();
            k++;
        end while (!(req === 1'b1 && ack === 1'b0) && k < 20);
        do_reset(1'b1);
        step();
        checks++;
        if (valid !== 1'b0 || req !== 1'b1 || iaddr !== 32'h0) begin
            failures++;
            $display("FAIL late_ack: v=%b req=%b ia=%h, required 0/1/00000000", valid, req, iaddr);
        end
        for (int i = 0; i < 20; i++) step();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_ia [4];
        exp_ia[0] = 32'hFFFF_FFF8;  exp_ia[1] = 32'hFFFF_FFFC;
        exp_ia[2] = 32'h0000_0000;  exp_ia[3] = 32'h0000_0004;
        @(negedge clk);
        rst_nw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (w_req !== 1'b1 || w_iaddr !== exp_ia[i]) begin
                failures++;
                $display("FAIL wrap_fetch[%0d]: req=%b ia=%h, required 1/%h", i, w_req, w_iaddr, exp_ia[i]);
            end
            if (i > 0) begin
                checks++;
                if (w_valid !== 1'b1 || w_addr !== exp_ia[i] || w_instr !== memf(exp_ia[i-1])) begin
                    failures++;
                    $display("FAIL wrap_out[%0d]: v=%b a=%h i=%h, required 1/%h/%h",
                             i, w_valid, w_addr, w_instr, exp_ia[i], memf(exp_ia[i-1]));
                end
            end
        end
        #1;
        rst_nw = 1'b0;
        #1;
        checks++;
        if ({w_req, w_iaddr, w_valid, w_addr, w_instr, w_flush} !== 99'h0) begin
            failures++;
            $display("FAIL wrap_reset: req=%b ia=%h v=%b a=%h, required all 0", w_req, w_iaddr, w_valid, w_addr);
        end
        @(negedge clk);
        rst_nw = 1'b1;
        @(negedge clk);
        checks++;
        if (w_req !== 1'b1 || w_iaddr !== 32'hFFFF_FFF8 || w_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_restart: req=%b ia=%h v=%b, required 1/fffffff8/0", w_req, w_iaddr, w_valid);
        end
    endtask

    initial begin
        n_cons = 0;  n_acks = 0;
        force_stall = 1'b0;  force_redir = 1'b0;  force_raddr = '0;
        set_mode(0, 0, 0, 0);
        reset_model();
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_redirect_drop();
        test_redirect_ack();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
